// File: rtl/ucode_sequencer_pkg.sv
// ucode_pkg: shared types and helpers for the microcode sequencer.
// Build option: UCODE_COND_BRANCH_EN enables the BRT/BRF ops.
package ucode_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CALL_OP = 3'd1,
    OP_CALL_FN = 3'd2,
    OP_JMP     = 3'd3,
    OP_BRT     = 3'd4,
    OP_BRF     = 3'd5,
    OP_ILL6    = 3'd6,
    OP_ILL7    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT,
    ST_ERR
  } state_e;

  localparam logic [1:0] PROG_SEL_CODE = 2'd0;
  localparam logic [1:0] PROG_SEL_OP   = 2'd1;
  localparam logic [1:0] PROG_SEL_FN   = 2'd2;
  localparam logic [1:0] PROG_SEL_RSV  = 2'd3;

  // Word layout is {op, tgt, eos, ctrl}; widths vary per instance.
  function automatic logic [31:0] word_field(
    input logic [127:0] w,
    input int           lsb,
    input int           width
  );
    logic [127:0] m;
    m = (128'(1) << width) - 128'(1);
    return 32'((w >> lsb) & m);
  endfunction

endpackage

// File: rtl/ucode_sequencer_stack.sv
// ucode_stack: return-address LIFO for the microcode sequencer.
// Top-of-stack is readable in the same cycle as the pop.
module ucode_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [SW-1:0] sp;

  assign full  = (sp == SW'(DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[IW'(sp - SW'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[IW'(sp)] <= din;
  end

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: programmable microcode sequencer for the multicycle control path.
// Define UCODE_COND_BRANCH_EN to enable BRT/BRF on cond_i.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int CTRL_W      = 32,
  parameter int DEPTH       = 256,
  parameter int OPCODE_W    = 6,
  parameter int FN_SEGS     = 64,
  parameter int STACK_DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = $clog2(FN_SEGS),
  localparam int WW = 3 + AW + 1 + CTRL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sos_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                cond_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [AW-1:0]       upc_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                halted_o,
  output logic                err_o,
  input  logic                prog_we_i,
  input  logic [1:0]          prog_sel_i,
  input  logic [AW-1:0]       prog_addr_i,
  input  logic [WW-1:0]       prog_data_i
);

  localparam logic [AW-1:0] INV = '1;

  logic [WW-1:0] code  [DEPTH];
  logic [AW-1:0] opseg [2**OPCODE_W];
  logic [AW-1:0] fnseg [FN_SEGS];

  state_e        state;
  logic [AW-1:0] upc;
  logic [AW-1:0] upc_inc;
  logic [AW-1:0] nxt_upc;
  logic [AW-1:0] call_tgt;
  logic [AW-1:0] tgt;
  logic [AW-1:0] sos_tgt;
  logic [AW-1:0] st_top;
  logic [WW-1:0] cur;
  logic [2:0]    op_bits;
  op_e           op;
  logic          eos;
  logic          at_end;
  logic          do_push;
  logic          do_pop;
  logic          go_err;
  logic          go_done;
  logic          seq;
  logic          st_full;
  logic          st_empty;
  logic          st_push;
  logic          st_pop;

  assign cur      = code[upc];
  assign op_bits  = 3'(word_field(128'(cur), CTRL_W + 1 + AW, 3));
  assign tgt      = AW'(word_field(128'(cur), CTRL_W + 1, AW));
  assign eos      = cur[CTRL_W];
  assign op       = op_e'(op_bits);
  assign upc_inc  = upc + AW'(1);
  assign at_end   = (upc == AW'(DEPTH - 1));
  assign sos_tgt  = opseg[opcode_i];
  assign call_tgt = (op == OP_CALL_OP) ? opseg[tgt[OPCODE_W-1:0]]
                                       : fnseg[tgt[FW-1:0]];
  assign upc_o    = upc;

`ifndef UCODE_COND_BRANCH_EN
  logic unused_cond;
  assign unused_cond = cond_i;
`endif

  // Next-address resolution for the word currently on ctrl_o.
  always_comb begin
    nxt_upc = upc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    go_err  = 1'b0;
    go_done = 1'b0;
    seq     = 1'b0;
    unique case (op)
      OP_NOP: seq = 1'b1;
      OP_CALL_OP, OP_CALL_FN: begin
        if (st_full || call_tgt == INV) begin
          go_err = 1'b1;
        end else begin
          do_push = 1'b1;
          nxt_upc = call_tgt;
        end
      end
      OP_JMP: nxt_upc = tgt;
`ifdef UCODE_COND_BRANCH_EN
      OP_BRT: begin
        if (cond_i) nxt_upc = tgt;
        else        seq = 1'b1;
      end
      OP_BRF: begin
        if (!cond_i) nxt_upc = tgt;
        else         seq = 1'b1;
      end
`endif
      default: go_err = 1'b1;
    endcase
    if (seq) begin
      if (eos && !st_empty) begin
        do_pop  = 1'b1;
        nxt_upc = st_top;
      end else if (eos) begin
        go_done = 1'b1;
      end else if (at_end) begin
        go_err = 1'b1;
      end
    end
  end

  assign st_push = (state == ST_RUN) && do_push;
  assign st_pop  = (state == ST_RUN) && do_pop;

  ucode_stack #(
    .W     (AW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (st_push),
    .pop   (st_pop),
    .din   (upc_inc),
    .top   (st_top),
    .full  (st_full),
    .empty (st_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      upc      <= '0;
      ctrl_o   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      halted_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sos_i) begin
            if (&opcode_i) begin
              state    <= ST_HALT;
              halted_o <= 1'b1;
            end else if (sos_tgt == INV) begin
              state <= ST_ERR;
              err_o <= 1'b1;
            end else begin
              state  <= ST_RUN;
              upc    <= sos_tgt;
              ctrl_o <= code[sos_tgt][CTRL_W-1:0];
              busy_o <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (go_err) begin
            state  <= ST_ERR;
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            ctrl_o <= '0;
          end else if (go_done) begin
            state  <= ST_IDLE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            ctrl_o <= '0;
          end else begin
            upc    <= nxt_upc;
            ctrl_o <= code[nxt_upc][CTRL_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Program memories are not reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (prog_we_i && state == ST_IDLE) begin
      unique case (prog_sel_i)
        PROG_SEL_CODE: code[prog_addr_i] <= prog_data_i;
        PROG_SEL_OP:   opseg[prog_addr_i[OPCODE_W-1:0]] <= prog_data_i[AW-1:0];
        PROG_SEL_FN:   fnseg[prog_addr_i[FW-1:0]] <= prog_data_i[AW-1:0];
        PROG_SEL_RSV:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed and random checks against a segment-walking model.
// Honours UCODE_COND_BRANCH_EN the same way as the design.
module tb_ucode_sequencer;

  localparam int MAXS    = 64;
  localparam int OC_DONE = 0;
  localparam int OC_ERR  = 1;
  localparam int OC_HALT = 2;
  localparam int OC_CAP  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sos_i = 1'b0;
  logic [5:0]  opcode_i = '0;
  logic        cond_i = 1'b0;
  logic [31:0] ctrl_o;
  logic [7:0]  upc_o;
  logic        busy_o;
  logic        done_o;
  logic        halted_o;
  logic        err_o;
  logic        prog_we_i = 1'b0;
  logic [1:0]  prog_sel_i = '0;
  logic [7:0]  prog_addr_i = '0;
  logic [43:0] prog_data_i = '0;

  logic [43:0] code_m  [256];
  logic [7:0]  opseg_m [64];
  logic [7:0]  fnseg_m [64];
  logic [7:0]  exp_upc [MAXS];
  logic [31:0] exp_ctrl[MAXS];
  bit          cond_v  [MAXS];

  int n_cmp = 0;
  int n_bad = 0;
  int oc;

  ucode_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sos_i       (sos_i),
    .opcode_i    (opcode_i),
    .cond_i      (cond_i),
    .ctrl_o      (ctrl_o),
    .upc_o       (upc_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .halted_o    (halted_o),
    .err_o       (err_o),
    .prog_we_i   (prog_we_i),
    .prog_sel_i  (prog_sel_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] mkw(input int op, input int tg,
                                      input bit e, input logic [31:0] c);
    logic [2:0] o;
    logic [7:0] t;
    o = 3'(op);
    t = 8'(tg);
    return {o, t, e, c};
  endfunction

  task automatic prog(input logic [1:0] sel, input int a, input logic [43:0] d);
    prog_we_i   = 1'b1;
    prog_sel_i  = sel;
    prog_addr_i = 8'(a);
    prog_data_i = d;
    if (sel == 2'd0)      code_m[a % 256] = d;
    else if (sel == 2'd1) opseg_m[a % 64] = d[7:0];
    else if (sel == 2'd2) fnseg_m[a % 64] = d[7:0];
    @(posedge clk);
    #1 prog_we_i = 1'b0;
  endtask

  // Walks a segment from the table/word rules; fills exp_upc/exp_ctrl.
  task automatic model_run(input logic [5:0] opc, output int n, output int res);
    logic [7:0]  pc;
    logic [7:0]  tv;
    logic [43:0] w;
    logic [7:0]  stk[$];
    int          op;
    n = 0;
    if (opc == 6'h3F) begin res = OC_HALT; return; end
    if (opseg_m[opc] == 8'hFF) begin res = OC_ERR; return; end
    pc = opseg_m[opc];
    while (1) begin
      if (n == MAXS) begin res = OC_CAP; return; end
      w = code_m[pc];
      exp_upc[n]  = pc;
      exp_ctrl[n] = w[31:0];
      op = int'(w[43:41]);
      n++;
      if (op == 1 || op == 2) begin
        tv = (op == 1) ? opseg_m[w[38:33]] : fnseg_m[w[38:33]];
        if (stk.size() == 8 || tv == 8'hFF) begin res = OC_ERR; return; end
        stk.push_back(pc + 8'd1);
        pc = tv;
        continue;
      end
      if (op == 3) begin pc = w[40:33]; continue; end
      if (op >= 6) begin res = OC_ERR; return; end
      if (op == 4 || op == 5) begin
`ifdef UCODE_COND_BRANCH_EN
        if (cond_v[n-1] == (op == 4)) begin pc = w[40:33]; continue; end
`else
        res = OC_ERR;
        return;
`endif
      end
      if (w[32]) begin
        if (stk.size() > 0) begin pc = stk.pop_back(); continue; end
        res = OC_DONE;
        return;
      end
      if (pc == 8'hFF) begin res = OC_ERR; return; end
      pc = pc + 8'd1;
    end
  endtask

  task automatic run_check(input logic [5:0] opc, input bit wr, output int res);
    int n;
    model_run(opc, n, res);
    opcode_i = opc;
    sos_i    = 1'b1;
    @(posedge clk);
    #1 sos_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("run_busy", busy_o, 1);
      check("run_upc", upc_o, exp_upc[k]);
      check("run_ctrl", ctrl_o, exp_ctrl[k]);
      cond_i      = cond_v[k];
      sos_i       = ($urandom_range(3) == 0);
      opcode_i    = 6'($urandom);
      prog_we_i   = wr && k < 2;
      prog_sel_i  = (k == 0) ? 2'd0 : 2'd1;
      prog_addr_i = (k == 0) ? 8'd21 : 8'd3;
      prog_data_i = (k == 0) ? mkw(0, 0, 1, 32'hDEAD) : 44'd0;
    end
    @(negedge clk);
    sos_i     = 1'b0;
    prog_we_i = 1'b0;
    case (res)
      OC_DONE: begin
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 0);
        check("done_ctrl", ctrl_o, 0);
      end
      OC_ERR: begin
        check("err_flag", err_o, 1);
        check("err_busy", busy_o, 0);
        check("err_ctrl", ctrl_o, 0);
      end
      OC_HALT: begin
        check("halt_flag", halted_o, 1);
        check("halt_busy", busy_o, 0);
        check("halt_ctrl", ctrl_o, 0);
      end
      default: check("cap_busy", busy_o, 1);
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", ctrl_o, 0);
    check("rst_upc", upc_o, 0);
    check("rst_flags", {busy_o, done_o, halted_o, err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic after_run(input int res);
    if (res == OC_DONE) begin
      @(negedge clk);
      check("done_once", done_o, 0);
    end else begin
      if (res != OC_CAP) begin
        sos_i    = 1'b1;
        opcode_i = 6'd0;
        @(posedge clk);
        #1 sos_i = 1'b0;
        @(negedge clk);
        check("stuck_busy", busy_o, 0);
        check("stuck_flag", err_o | halted_o, 1);
      end
      do_reset();
    end
  endtask

  initial begin
    foreach (cond_v[i]) cond_v[i] = 1'b0;
    @(negedge clk);
    check("rst_ctrl0", ctrl_o, 0);
    check("rst_upc0", upc_o, 0);
    check("rst_flags0", {busy_o, done_o, halted_o, err_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 256; a++) prog(0, a, mkw(0, 0, 1, 32'(a)));
    for (int a = 0; a < 64; a++) begin
      prog(1, a, 44'hFF);
      prog(2, a, 44'hFF);
    end

    // two-word segment, then a back-to-back start
    prog(0, 0, mkw(0, 0, 0, 32'd1));
    prog(0, 1, mkw(0, 0, 1, 32'd2));
    prog(1, 0, 44'd0);
    @(negedge clk);
    run_check(6'd0, 1'b0, oc);
    run_check(6'd0, 1'b0, oc);
    after_run(oc);

    // function-segment call and return
    prog(0, 0, mkw(2, 1, 0, 32'h10));
    prog(0, 1, mkw(0, 0, 1, 32'h11));
    prog(0, 4, mkw(0, 0, 1, 32'h14));
    prog(2, 1, 44'd4);
    @(negedge clk);
    run_check(6'd0, 1'b0, oc);
    after_run(oc);

    // unbounded recursion overflows the return stack
    prog(0, 8, mkw(1, 1, 0, 32'h88));
    prog(1, 1, 44'd8);
    @(negedge clk);
    run_check(6'd1, 1'b0, oc);
    check("recurse_err", oc, OC_ERR);
    after_run(oc);

    // conditional branch both ways
    prog(0, 0, mkw(0, 0, 0, 32'hB0));
    prog(0, 1, mkw(0, 0, 0, 32'hB1));
    prog(0, 2, mkw(4, 10, 0, 32'hB2));
    prog(0, 3, mkw(0, 0, 1, 32'hB3));
    prog(0, 10, mkw(0, 0, 1, 32'hBA));
    prog(1, 2, 44'd0);
    for (int c = 1; c >= 0; c--) begin
      foreach (cond_v[i]) cond_v[i] = (c == 1);
      @(negedge clk);
      run_check(6'd2, 1'b0, oc);
      after_run(oc);
    end

    @(negedge clk);
    run_check(6'h3F, 1'b0, oc);
    after_run(oc);

    // sequential step past the last word
    prog(0, 254, mkw(0, 0, 0, 32'hFE));
    prog(0, 255, mkw(0, 0, 0, 32'hFF));
    prog(1, 4, 44'd254);
    // call into an invalid table entry, and an illegal op
    prog(0, 30, mkw(2, 5, 0, 32'h30));
    prog(1, 5, 44'd30);
    prog(0, 31, mkw(6, 0, 1, 32'h31));
    prog(1, 6, 44'd31);
    for (int o = 4; o <= 6; o++) begin
      @(negedge clk);
      run_check(6'(o), 1'b0, oc);
      after_run(oc);
    end

    // writes during RUN are dropped
    for (int a = 20; a < 23; a++) prog(0, a, mkw(0, 0, 0, 32'(a + 'h100)));
    prog(0, 23, mkw(0, 0, 1, 32'h123));
    prog(1, 3, 44'd20);
    @(negedge clk);
    run_check(6'd3, 1'b1, oc);
    after_run(oc);
    run_check(6'd3, 1'b0, oc);
    after_run(oc);

    opcode_i = 6'd3;
    sos_i    = 1'b1;
    @(posedge clk);
    #1 sos_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy_o, 1);
    do_reset();
    check("mid_no_done", done_o, 0);

    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 47; a++) begin
        int rv;
        int op;
        int tg;
        rv = $urandom_range(15);
        op = (rv < 8) ? 0 : (rv == 8) ? 1 : (rv == 9) ? 2 : (rv == 10) ? 3 :
             (rv < 13) ? 4 : (rv < 15) ? 5 : 6 + $urandom_range(1);
        tg = (op == 1 || op == 2) ? $urandom_range(15) : $urandom_range(46);
        prog(0, a, mkw(op, tg, $urandom_range(3) == 0, $urandom));
      end
      prog(0, 47, mkw(0, 0, 1, 32'h47));
      for (int a = 0; a < 16; a++) begin
        prog(1, a, ($urandom_range(9) == 0) ? 44'hFF : 44'($urandom_range(46)));
        prog(2, a, ($urandom_range(9) == 0) ? 44'hFF : 44'($urandom_range(46)));
      end
      prog_we_i   = 1'b1;
      prog_sel_i  = 2'd3;
      prog_addr_i = 8'd5;
      prog_data_i = 44'h3;
      @(posedge clk);
      #1 prog_we_i = 1'b0;
      for (int s = 0; s < 5; s++) begin
        logic [5:0] opc;
        foreach (cond_v[i]) cond_v[i] = 1'($urandom);
        opc = ($urandom_range(7) == 0) ? 6'h3F : 6'($urandom_range(15));
        @(negedge clk);
        run_check(opc, 1'b0, oc);
        after_run(oc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Parametrised, programmable microcode sequencer for the multicycle MIPS control path. On each start-of-segment request it walks a microcode segment selected by the instruction opcode and drives one control word per cycle. Segments can be nested through opcode and function segment calls, absolute jumps and (optionally) conditional branches on a datapath flag. Microcode and segment tables are loaded at run time through a write port, and stack faults are reported instead of being silently ignored.

## Interface
- `CTRL_W`, default 32: control word width.
- `DEPTH`, default 256: microcode words; `AW = $clog2(DEPTH)`.
- `OPCODE_W`, default 6: opcode width; the opcode segment table has `2**OPCODE_W` entries.
- `FN_SEGS`, default 64: function-segment table entries; `FW = $clog2(FN_SEGS)`.
- `STACK_DEPTH`, default 8: return-stack entries.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sos_i`, in, 1: start-of-segment request, sampled only in IDLE.
- `opcode_i`, in, OPCODE_W: opcode, sampled with `sos_i`.
- `cond_i`, in, 1: datapath branch flag.
- `ctrl_o`, out, CTRL_W: registered control word.
- `upc_o`, out, AW: address of the word currently driven.
- `busy_o`, out, 1: high in RUN.
- `done_o`, out, 1: one-cycle pulse at the end of the top-level segment.
- `halted_o`, out, 1: the all-ones opcode was accepted.
- `err_o`, out, 1: sticky fault flag.
- `prog_we_i`, in, 1: program write enable.
- `prog_sel_i`, in, 2: write target; 0 = code, 1 = opcode table, 2 = function table, 3 = reserved (write ignored).
- `prog_addr_i`, in, AW: write address.
- `prog_data_i`, in, `3+AW+1+CTRL_W`: write data.

## Operation
- Word format `{op[2:0], tgt[AW-1:0], eos, ctrl}`.
- op encodings:
  - 0 NOP
  - 1 CALL_OP: target is `opseg[tgt[OPCODE_W-1:0]]`
  - 2 CALL_FN: target is `fnseg[tgt[FW-1:0]]`
  - 3 JMP to `tgt`
  - 4 BRT: jump to `tgt` if `cond_i`
  - 5 BRF: jump to `tgt` if `!cond_i`
  - 6, 7: illegal, go to ERR.
- Segment table entries are AW wide. The all-ones value marks an invalid entry.
- States:
  - IDLE: `sos_i` with the all-ones opcode goes to HALT. `sos_i` whose `opseg[opcode_i]` is all-ones goes to ERR. Any other `sos_i` loads `upc = opseg[opcode_i]` and goes to RUN.
  - RUN: the next address is resolved from the current word in this priority order:
    1. CALL (push `upc+1`)
    2. JMP or taken branch
    3. `eos` with non-empty stack: pop
    4. `eos` with empty stack: `done_o`, go to IDLE
    5. otherwise `upc+1`
  - HALT and ERR are left only by reset.
- `eos` on a CALL, JMP or taken-branch word is ignored.
- Errors that go to ERR: CALL with the stack full, CALL to an invalid table entry, illegal op, `upc+1` wrapping past `DEPTH-1`.
- In ERR and HALT: `ctrl_o` is 0, `busy_o` is 0, the stack is frozen.
- Programming: writes are accepted only in IDLE and dropped in any other state. The code memory and tables are not reset.
- `sos_i` in RUN, HALT or ERR is ignored.

## Timing
- Reset values:
  - state IDLE, stack pointer 0
  - `ctrl_o` = 0, `upc_o` = 0
  - `busy_o`, `done_o`, `halted_o`, `err_o` = 0
- `sos_i` accepted at edge N: at N+1 `ctrl_o` holds the first word's ctrl, `busy_o` = 1. This gives one-cycle start latency.
- One word per cycle. A CALL, jump or pop costs no bubble: the target word is presented on the next cycle.
- Final `eos` word presented at cycle M: at M+1 `done_o` = 1 for one cycle, `ctrl_o` = 0, `busy_o` = 0. A `sos_i` at M+1 gives its first word at M+2.
- `cond_i` is sampled in the same cycle its branch word is on `ctrl_o`.
- A program write at edge N is visible to a `sos_i` accepted at edge N+1.
- Reset mid-RUN clears outputs immediately; no `done_o` is produced.

## Configuration
- `UCODE_COND_BRANCH_EN` defined: BRT and BRF behave as described, using `cond_i`.
- `UCODE_COND_BRANCH_EN` undefined: ops 4 and 5 are illegal and go to ERR, and `cond_i` is unused.

## Structure
- `ucode_pkg` holds:
  - the `op_e` enum
  - the state enum
  - the `PROG_SEL_*` constants
  - a field-extraction function for the word format
- Sub-module `ucode_stack`: parametrised LIFO with push/pop, full/empty flags and a same-cycle read of the top entry.

## Test plan
- Code words 0 (`ctrl=1`) and 1 (`ctrl=2`, eos) loaded; `opseg[0] = 0`; `sos_i`, opcode 0 → `ctrl_o` reads 1 then 2, then `done_o` pulses and `busy_o` drops. Total of 3 cycles after the `sos_i` edge.
- Nesting: word 0 is CALL_FN 1 with `fnseg[1] = 4`; word 4 is eos → sequence is upc 0, 4, 1, then `done_o`. Stack pointer returns to 0.
- Recursive CALL exceeding `STACK_DEPTH` 8 → `err_o` = 1 on the 9th CALL. Further `sos_i` is ignored until `rst_n` is asserted.
- With `UCODE_COND_BRANCH_EN`: BRT at word 2 to target 10:
  - `cond_i` = 1 → next upc is 10
  - `cond_i` = 0 → next upc is 3
  - without the macro → `err_o` = 1
- Opcode `6'h3F` → `halted_o` = 1 and `ctrl_o` stays 0. A program write during RUN is dropped; read back after `done_o` shows the old word unchanged.
